traceback_reader: RTL and testbench
===================================

Name: traceback_reader

Overview:
- Consumes the per-cell direction words that the two-piece affine-gap systolic array stores in direction memory.
- Given the end cell of an alignment, walks the pointers backwards through the H, E1, F1, E2 and F2 layers.
- Emits one alignment op per step on a valid/ready stream; ops come out in reverse order, from the end cell towards the start.
- Sits between the direction RAM read port and the host or CIGAR packer.

Parameters:
- ROW_W, 10, width of the row index (S position).
- COL_W, 10, width of the column index (T position).
- CNT_W, 12, width of the op counter.
- DIR_W, 7, direction word width (encoding fixed below).

Ports:
- clk  in  1  clock.
- reset_i  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a traceback.
- end_row  in  ROW_W  end cell row, sampled when start is accepted.
- end_col  in  COL_W  end cell column, sampled when start is accepted.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at the end of a traceback.
- error  out  1  valid with done; an illegal direction code was seen.
- start_row  out  ROW_W  row at which the walk terminated; valid with done, held until next start.
- start_col  out  COL_W  column at which the walk terminated; valid with done, held until next start.
- op_count  out  CNT_W  number of ops emitted; valid with done.
- dir_rd_en  out  1  direction memory read strobe.
- dir_row  out  ROW_W  read row address.
- dir_col  out  COL_W  read column address.
- dir_rdata  in  DIR_W  read data, valid exactly 1 cycle after dir_rd_en.
- op_valid  out  1  op available.
- op_ready  in  1  downstream accepts op.
- op_code  out  2  0 = M, 1 = X, 2 = I (gap in S, consumes T), 3 = D (consumes S).

Behaviour:
- Direction word encoding:
  - [2:0] is the H origin: 0 diag match, 1 diag mismatch, 2 E1, 3 F1, 4 E2, 5 F2, 7 STOP; 6 is illegal.
  - [3] E1 extend, [4] F1 extend, [5] E2 extend, [6] F2 extend.
- Reset values: all outputs 0; state IDLE; internal i, j, layer and count cleared; layer = H.
- States: IDLE, FETCH, WAIT, STEP, EMIT, DONE.
- IDLE:
  - When start=1, latch i=end_row, j=end_col, layer=H, count=0 and raise busy.
  - If i==0 or j==0, go to DONE with no fetch; otherwise go to FETCH.
  - start is ignored while busy.
- FETCH: dir_rd_en=1, dir_row=i, dir_col=j for one cycle; go to WAIT.
- WAIT: latch dir_rdata into dir_reg; go to STEP.
- STEP decodes dir_reg using the current layer:
  - Layer H, code 0 or 1: op = M or X, i--, j--, go to EMIT.
  - Layer H, code 2–5: layer := E1/F1/E2/F2 and stay in STEP for 1 cycle; no refetch and no op.
  - Layer H, code 7: go to DONE.
  - Layer H, code 6: set error, go to DONE.
  - Layer E1 or E2: op = I, j--. Layer stays if its extend bit is 1, otherwise becomes H. Go to EMIT.
  - Layer F1 or F2: op = D, i--. Same extend rule as E. Go to EMIT.
- EMIT:
  - op_valid=1, with op_code held stable until op_ready.
  - On handshake (op_valid & op_ready): count++ saturating at all-ones.
  - After the handshake, go to DONE if i==0 or j==0, else go to FETCH.
- DONE: done=1 for one cycle; start_row=i, start_col=j, op_count=count, error as set; busy=0 next cycle; return to IDLE.
- Throughput: minimum 4 cycles per op with op_ready held high (FETCH, WAIT, STEP, EMIT). A layer switch adds 1 cycle.
- i and j never underflow: the zero check happens before any fetch.
- Asynchronous reset mid-walk aborts immediately. No done pulse is produced, and op_valid drops.
- op_valid never depends combinationally on op_ready.

Test Plan:
- Diagonal walk:
  - Stimulus: cells (3,3), (2,2), (1,1) code 0; start end=(3,3); op_ready=1.
  - Response: ops M, M, M; done with start=(0,0), count=3, error=0; 12 cycles from start to last handshake.
- Affine E1 gap:
  - Stimulus: (2,4) H code 2; (2,4) E1 extend=1; (2,3) E1 extend=0; (2,2) code 1; (1,1) code 7.
  - Response: ops I, I, X; done with start=(1,1), count=3.
- Backpressure:
  - Stimulus: diagonal case with op_ready low for 5 cycles at the 2nd op.
  - Response: op_valid and op_code stay stable; no extra fetch; final count=3.
- Boundary start:
  - Stimulus: start end=(0,7).
  - Response: no dir_rd_en; done with count=0 and start=(0,7).
- Illegal code:
  - Stimulus: (5,5) code 6.
  - Response: done with error=1, count=0; a later start runs normally with error=0.
- Reset mid-walk and ignored start:
  - Stimulus: assert reset_i=0 during EMIT; separately, pulse start while busy.
  - Response: on reset, all outputs go to 0 asynchronously with no done pulse. The start pulsed while busy has no effect on end coordinates.

Source files
------------

// File: rtl/traceback_reader.sv
// traceback_reader: walks affine-gap direction pointers back from an end cell,
// emitting one alignment op per step on a valid/ready stream.
module traceback_reader #(
  parameter int ROW_W = 10,
  parameter int COL_W = 10,
  parameter int CNT_W = 12,
  parameter int DIR_W = 7
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             start,
  input  logic [ROW_W-1:0] end_row,
  input  logic [COL_W-1:0] end_col,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [ROW_W-1:0] start_row,
  output logic [COL_W-1:0] start_col,
  output logic [CNT_W-1:0] op_count,
  output logic             dir_rd_en,
  output logic [ROW_W-1:0] dir_row,
  output logic [COL_W-1:0] dir_col,
  input  logic [DIR_W-1:0] dir_rdata,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [1:0]       op_code
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, STEP, EMIT, DONE} state_t;
  typedef enum logic [2:0] {L_H, L_E1, L_F1, L_E2, L_F2} layer_t;
  state_t state, state_n;
  layer_t layer, layer_n;
  logic [ROW_W-1:0] i, i_n;
  logic [COL_W-1:0] j, j_n;
  logic [CNT_W-1:0] count, count_n;
  logic [DIR_W-1:0] dir_reg, dir_n;
  logic [1:0] op, op_n;
  logic err, err_n, ext, horiz;
  // gap layers E1/F1/E2/F2 (1..4) map onto extend bits 3..6
  assign ext = dir_reg[3'(layer) + 3'd2];
  assign horiz = (layer == L_E1) || (layer == L_E2);
  always_comb begin
    state_n = state;
    layer_n = layer;
    i_n = i;
    j_n = j;
    count_n = count;
    dir_n = dir_reg;
    op_n = op;
    err_n = err;
    case (state)
      IDLE: if (start) begin
        i_n = end_row;
        j_n = end_col;
        layer_n = L_H;
        count_n = '0;
        err_n = 1'b0;
        state_n = (end_row == '0 || end_col == '0) ? DONE : FETCH;
      end
      FETCH: state_n = WAIT;
      WAIT: begin
        dir_n = dir_rdata;
        state_n = STEP;
      end
      STEP: if (layer != L_H) begin
        op_n = horiz ? 2'd2 : 2'd3;
        i_n = horiz ? i : i - ROW_W'(1);
        j_n = horiz ? j - COL_W'(1) : j;
        layer_n = ext ? layer : L_H;
        state_n = EMIT;
      end else if (dir_reg[2:1] == 2'b00) begin
        op_n = dir_reg[1:0];
        i_n = i - ROW_W'(1);
        j_n = j - COL_W'(1);
        state_n = EMIT;
      end else if (dir_reg[2:1] == 2'b11) begin
        err_n = ~dir_reg[0];
        state_n = DONE;
      end else begin
        layer_n = layer_t'(dir_reg[2:0] - 3'd1);
      end
      EMIT: if (op_ready) begin
        count_n = count + {{(CNT_W-1){1'b0}}, ~&count};
        state_n = (i == '0 || j == '0) ? DONE : FETCH;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state <= IDLE;
      layer <= L_H;
      i <= '0;
      j <= '0;
      count <= '0;
      dir_reg <= '0;
      op <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      layer <= layer_n;
      i <= i_n;
      j <= j_n;
      count <= count_n;
      dir_reg <= dir_n;
      op <= op_n;
      err <= err_n;
    end
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign error = err;
  assign start_row = i;
  assign start_col = j;
  assign op_count = count;
  assign dir_rd_en = state == FETCH;
  assign dir_row = i;
  assign dir_col = j;
  assign op_valid = state == EMIT;
  assign op_code = op;
endmodule

// File: tb/tb_traceback_reader.sv
// tb_traceback_reader: directed traceback walks over a small direction memory model.
module tb_traceback_reader;
  logic clk = 0, reset_i = 0, start = 0, op_ready = 0;
  logic [9:0] end_row = 0, end_col = 0;
  logic busy, done, error, dir_rd_en, op_valid;
  logic [9:0] start_row, start_col, dir_row, dir_col;
  logic [11:0] op_count;
  logic [6:0] dir_rdata = 0;
  logic [1:0] op_code;
  logic [6:0] mem [0:7][0:7];
  logic [1:0] ops [$];
  int n_assert = 0, n_fail = 0, cyc = 0, fetches = 0, n_done = 0, last_hs = 0;
  int s, f, d;

  traceback_reader dut (
    .clk(clk), .reset_i(reset_i), .start(start), .end_row(end_row), .end_col(end_col),
    .busy(busy), .done(done), .error(error), .start_row(start_row), .start_col(start_col),
    .op_count(op_count), .dir_rd_en(dir_rd_en), .dir_row(dir_row), .dir_col(dir_col),
    .dir_rdata(dir_rdata), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (dir_rd_en) begin
      dir_rdata <= mem[dir_row[2:0]][dir_col[2:0]];
      fetches++;
    end
    if (op_valid && op_ready) begin
      ops.push_back(op_code);
      last_hs = cyc;
    end
    if (done) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [9:0] r, input logic [9:0] c, output int sc);
    @(negedge clk);
    ops.delete();
    start = 1; end_row = r; end_col = c;
    sc = cyc + 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 200) begin @(negedge clk); k++; end
    chk({tag, " done timeout"}, 32'(k < 200), 1);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!op_valid && k < 200) begin @(negedge clk); k++; end
    chk({tag, " valid timeout"}, 32'(k < 200), 1);
  endtask

  task automatic chk_ops(input string tag, input logic [1:0] e0, input logic [1:0] e1, input logic [1:0] e2);
    logic [1:0] e [3];
    e = '{e0, e1, e2};
    chk({tag, " nops"}, ops.size(), 3);
    for (int k = 0; k < 3; k++)
      chk({tag, " op"}, (k < ops.size()) ? 32'(ops[k]) : 32'hdead, 32'(e[k]));
  endtask

  task automatic set_diag();
    mem[3][3] = 7'h00; mem[2][2] = 7'h00; mem[1][1] = 7'h00;
  endtask

  initial begin
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) mem[r][c] = 7'h00;
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst op_valid", op_valid, 0);
    chk("rst rd_en", dir_rd_en, 0);
    chk("rst op_count", op_count, 0);
    chk("rst start_row", start_row, 0);
    @(negedge clk);
    reset_i = 1;

    // diagonal walk
    set_diag();
    op_ready = 1;
    f = fetches;
    run(3, 3, s);
    chk("diag busy", busy, 1);
    wait_done("diag");
    chk_ops("diag", 2'd0, 2'd0, 2'd0);
    chk("diag row", start_row, 0);
    chk("diag col", start_col, 0);
    chk("diag count", op_count, 3);
    chk("diag error", error, 0);
    chk("diag latency", last_hs - s, 12);
    chk("diag fetches", fetches - f, 3);
    @(negedge clk);
    chk("diag busy drop", busy, 0);

    // affine E1 gap
    mem[2][4] = 7'h0A; mem[2][3] = 7'h00; mem[2][2] = 7'h01; mem[1][1] = 7'h07;
    f = fetches;
    run(2, 4, s);
    wait_done("gap");
    chk_ops("gap", 2'd2, 2'd2, 2'd1);
    chk("gap row", start_row, 1);
    chk("gap col", start_col, 1);
    chk("gap count", op_count, 3);
    chk("gap error", error, 0);
    chk("gap fetches", fetches - f, 4);

    // backpressure on the second op
    set_diag();
    op_ready = 0;
    run(3, 3, s);
    wait_valid("bp1");
    op_ready = 1;
    @(negedge clk);
    op_ready = 0;
    wait_valid("bp2");
    f = fetches;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp hold valid", op_valid, 1);
      chk("bp hold code", op_code, 0);
    end
    chk("bp no fetch", fetches - f, 0);
    op_ready = 1;
    wait_done("bp");
    chk_ops("bp", 2'd0, 2'd0, 2'd0);
    chk("bp count", op_count, 3);

    // boundary start
    f = fetches;
    run(0, 7, s);
    wait_done("bnd");
    chk("bnd fetches", fetches - f, 0);
    chk("bnd count", op_count, 0);
    chk("bnd row", start_row, 0);
    chk("bnd col", start_col, 7);

    // illegal code, then a normal walk
    mem[5][5] = 7'h06;
    run(5, 5, s);
    wait_done("ill");
    chk("ill error", error, 1);
    chk("ill count", op_count, 0);
    chk("ill row", start_row, 5);
    run(3, 3, s);
    wait_done("ill2");
    chk("ill2 error", error, 0);
    chk("ill2 count", op_count, 3);

    // asynchronous reset during EMIT
    op_ready = 0;
    run(3, 3, s);
    wait_valid("rst");
    d = n_done;
    #2 reset_i = 0;
    #1;
    chk("arst op_valid", op_valid, 0);
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    chk("arst row", start_row, 0);
    repeat (3) @(negedge clk);
    chk("arst no done", n_done - d, 0);
    reset_i = 1;
    op_ready = 1;

    // start pulsed while busy is ignored
    run(3, 3, s);
    @(negedge clk);
    start = 1; end_row = 0; end_col = 7;
    @(negedge clk);
    start = 0;
    wait_done("ign");
    chk("ign count", op_count, 3);
    chk("ign row", start_row, 0);
    chk("ign col", start_col, 0);
    @(negedge clk);
    chk("ign idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
